muldiv_ctrl: RTL
================

Name: muldiv_ctrl

Overview:
- Sequencer and owner of the HI/LO register pair for the execute stage.
- Accepts multiply/divide commands decoded as mult/multu/div/divu/mul, plus mthi/mtlo writes.
- Runs a fixed-latency multiply or a 32-iteration radix-2 restoring divide.
- Raises a stall toward the pipeline hazard logic while busy, and commits results to HI/LO, or returns the product for mul.

Parameters:
- MUL_LAT, 2: cycles spent in MUL state before commit (>=1).
- DIV_ITER, 32: divide iterations; fixed at 32 for MIPS32, exposed only for fast simulation builds.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  valid mult/multu/div/divu/mul in EX this cycle.
- op  in  2  00 mult, 01 multu, 10 div, 11 divu.
- no_hilo  in  1  with start: mul instruction; result to product, HI/LO untouched.
- src_a  in  32  rs_data (multiplicand / dividend).
- src_b  in  32  rt_data (multiplier / divisor).
- flush  in  1  exception/eret flush; cancels a command in flight or being issued.
- hi_wen  in  1  mthi write.
- lo_wen  in  1  mtlo write.
- wdata  in  32  data for mthi/mtlo.
- hi  out  32  HI register.
- lo  out  32  LO register.
- product  out  32  low 32 bits of the mul result, valid while done=1.
- busy  out  1  stall request to hazard unit.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; hi, lo, product, all counters and operand registers = 0; done=0.
- busy = (state!=IDLE) | (start & ~flush). It is combinational, so the issuing instruction stalls in its own cycle. busy=0 in the cycle done=1.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - On start & ~flush: latch op, no_hilo, src_a, src_b.
  - op[1]=0 -> MUL with cnt=MUL_LAT-1.
  - op[1]=1 -> DIV.
  - start ignored outside IDLE.
- MUL:
  - 64-bit product: signed for op=00, unsigned for 01.
  - Decrement cnt; when cnt==0 -> IDLE.
  - On that edge, commit {hi,lo}=product64 unless no_hilo; product=product64[31:0]; done=1 the following cycle.
  - Latency from start to HI/LO visible: MUL_LAT+1 edges.
- DIV:
  - Signed (op=10): operate on magnitudes |a|, |b|.
  - Each cycle shift the remainder/quotient pair left 1, trial-subtract the divisor, set quotient bit on non-negative.
  - DIV_ITER cycles, then -> FIX.
- FIX:
  - Apply signs: quotient negative iff signs differ; remainder takes the dividend's sign.
  - Commit lo=quotient, hi=remainder; done=1; -> IDLE.
  - Total: DIV_ITER+2 edges from start.
- Arithmetic boundary cases:
  - Divide by zero, no exception: lo=0xFFFFFFFF, hi=src_a (unsigned) / src_a (signed).
  - 0x80000000 / 0xFFFFFFFF signed: lo=0x80000000, hi=0.
- flush:
  - With state!=IDLE: return to IDLE next edge; no commit, no done; HI/LO keep prior values.
  - flush with start in IDLE: command not accepted.
- mthi/mtlo:
  - hi_wen/lo_wen write wdata on the edge regardless of state, and are not gated by flush (the hazard unit gates them).
  - An in-flight op committing on the same edge or later overwrites both HI and LO; a commit has priority over hi_wen/lo_wen on the same edge.
- Reset mid-operation: immediate return to IDLE with all values zeroed; no done.

Optional Feature:
- Macro: MULDIV_EARLY_EXIT_EN.
- Defined:
  - In IDLE, a div/divu with src_b==0, or with |src_a| < |src_b| (magnitude compare), goes straight to FIX.
  - FIX commits the boundary result (lo=0 for the |a|<|b| case, hi=src_a), giving a 2-edge latency.
- Undefined: every divide takes the full DIV_ITER+2 edges.
- Results are bit-identical either way.

Test Plan:
- multu a=0xFFFFFFFF b=0xFFFFFFFF -> after 3 edges (MUL_LAT=2): hi=0xFFFFFFFE, lo=0x00000001; done high exactly 1 cycle; busy high from the start cycle until done.
- div a=0xFFFFFFF9 (-7) b=2 -> after 34 edges: lo=0xFFFFFFFD, hi=0xFFFFFFFF; busy high for 34 cycles.
- divu a=100 b=0 -> lo=0xFFFFFFFF, hi=100; block returns to IDLE, no hang. Repeat with MULDIV_EARLY_EXIT_EN: same result in 2 edges.
- mul (no_hilo=1, op=00) a=3 b=0xFFFFFFFC after preloading hi=0x11, lo=0x22 via mthi/mtlo -> product=0xFFFFFFF4 with done; hi=0x11, lo=0x22 unchanged.
- div 0x80000000/0xFFFFFFFF, then flush asserted on the 10th busy cycle -> next cycle busy=0; no done; hi/lo equal pre-issue values.
- resetn pulsed low for 1 cycle mid-divide -> hi, lo, product, busy, done all 0 asynchronously. A new multu 6*7 after release gives lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and multiply/divide sequencer for the execute stage.
// Optional build macro MULDIV_EARLY_EXIT_EN: trivial divides skip the iteration loop.
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT  = 2,
  parameter int unsigned DIV_ITER = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic        no_hilo_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  input  logic        hi_wen_i,
  input  logic        lo_wen_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] product_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned MaxCnt = (MUL_LAT > DIV_ITER) ? MUL_LAT : DIV_ITER;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StFix  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            uns_q, uns_d;
  logic            no_hilo_q, no_hilo_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     bmag_q, bmag_d;
  logic [31:0]     rem_q, rem_d;
  logic [31:0]     quo_q, quo_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic [31:0]     product_q, product_d;
  logic            done_q, done_d;

  logic        accept;
  logic [31:0] amag_in, bmag_in;
  logic [63:0] ext_a, ext_b, prod64;
  logic [32:0] rem_sh;
  logic        trial_ge;
  logic [31:0] trial_diff;
  logic [31:0] quo_fix, rem_fix;

  assign accept = start_i & ~flush_i;

  // Magnitudes only matter for signed div (op=10); divu passes operands through.
  assign amag_in = (~op_i[0] & src_a_i[31]) ? -src_a_i : src_a_i;
  assign bmag_in = (~op_i[0] & src_b_i[31]) ? -src_b_i : src_b_i;

  // Low 64 bits of an extended 64x64 product are correct for both signed and unsigned.
  assign ext_a  = {(uns_q ? 32'd0 : {32{a_q[31]}}), a_q};
  assign ext_b  = {(uns_q ? 32'd0 : {32{b_q[31]}}), b_q};
  assign prod64 = ext_a * ext_b;

  assign rem_sh     = {rem_q, quo_q[31]};
  assign trial_ge   = rem_sh >= {1'b0, bmag_q};
  assign trial_diff = rem_sh[31:0] - bmag_q;

  always_comb begin
    quo_fix = (~uns_q & (a_q[31] ^ b_q[31])) ? -quo_q : quo_q;
    rem_fix = (~uns_q & a_q[31]) ? -rem_q : rem_q;
    if (b_q == 32'd0) begin
      quo_fix = 32'hFFFF_FFFF;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    uns_d     = uns_q;
    no_hilo_d = no_hilo_q;
    a_d       = a_q;
    b_d       = b_q;
    bmag_d    = bmag_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    hi_d      = hi_wen_i ? wdata_i : hi_q;
    lo_d      = lo_wen_i ? wdata_i : lo_q;
    product_d = product_q;
    done_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          uns_d     = op_i[0];
          no_hilo_d = no_hilo_i;
          a_d       = src_a_i;
          b_d       = src_b_i;
          if (!op_i[1]) begin
            state_d = StMul;
            cnt_d   = CntW'(MUL_LAT - 1);
          end else begin
            state_d = StDiv;
            cnt_d   = CntW'(DIV_ITER - 1);
            bmag_d  = bmag_in;
            rem_d   = 32'd0;
            quo_d   = amag_in;
`ifdef MULDIV_EARLY_EXIT_EN
            // Quotient is 0 (or forced all-ones for /0 in FIX); remainder is |a|.
            if ((bmag_in == 32'd0) || (amag_in < bmag_in)) begin
              state_d = StFix;
              rem_d   = amag_in;
              quo_d   = 32'd0;
            end
`endif
          end
        end
      end
      StMul: begin
        if (flush_i) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d   = StIdle;
          product_d = prod64[31:0];
          done_d    = 1'b1;
          if (!no_hilo_q) begin
            hi_d = prod64[63:32];
            lo_d = prod64[31:0];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDiv: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          rem_d = trial_ge ? trial_diff : rem_sh[31:0];
          quo_d = {quo_q[30:0], trial_ge};
          if (cnt_q == '0) begin
            state_d = StFix;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!flush_i) begin
          hi_d   = rem_fix;
          lo_d   = quo_fix;
          done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      uns_q     <= 1'b0;
      no_hilo_q <= 1'b0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      bmag_q    <= 32'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      product_q <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      uns_q     <= uns_d;
      no_hilo_q <= no_hilo_d;
      a_q       <= a_d;
      b_q       <= b_d;
      bmag_q    <= bmag_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign busy_o    = (state_q != StIdle) | accept;
  assign done_o    = done_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign product_o = product_q;

endmodule
